// File: rtl/round_key_reader_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the round-key reader.
package round_key_reader_pkg;

  localparam int unsigned KEY_WIDTH          = 128;
  localparam int unsigned NUM_ROUNDS         = 10;
  localparam int unsigned NUM_KEYS           = NUM_ROUNDS + 1;
  localparam int unsigned EXPANDED_KEY_WIDTH = KEY_WIDTH * NUM_KEYS;
  localparam int unsigned IDX_W              = 4;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned COLS               = KEY_WIDTH / WORD_W;

  // AES field reduction polynomial (x^8 + x^4 + x^3 + x + 1, low byte)
  localparam logic [7:0] GF_POLY   = 8'h1b;
  localparam logic [3:0] GF_MUL_09 = 4'h9;
  localparam logic [3:0] GF_MUL_0B = 4'hb;
  localparam logic [3:0] GF_MUL_0D = 4'hd;
  localparam logic [3:0] GF_MUL_0E = 4'he;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using the xtime ladder
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (b[0] ? a : 8'h00) ^ (b[1] ? x2 : 8'h00) ^
           (b[2] ? x4 : 8'h00) ^ (b[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/round_key_reader_inv_mix_columns_word.sv
// Combinational InvMixColumns on one 32-bit AES column (row 0 in the MSB byte).
module inv_mix_columns_word
  import round_key_reader_pkg::*;
(
  input  logic [WORD_W-1:0] col_in,
  output logic [WORD_W-1:0] col_out_c
);

  logic [7:0] s0, s1, s2, s3;

  always_comb begin
    s0 = col_in[31:24];
    s1 = col_in[23:16];
    s2 = col_in[15:8];
    s3 = col_in[7:0];
    col_out_c[31:24] = gf_mul(s0, GF_MUL_0E) ^ gf_mul(s1, GF_MUL_0B) ^
                       gf_mul(s2, GF_MUL_0D) ^ gf_mul(s3, GF_MUL_09);
    col_out_c[23:16] = gf_mul(s0, GF_MUL_09) ^ gf_mul(s1, GF_MUL_0E) ^
                       gf_mul(s2, GF_MUL_0B) ^ gf_mul(s3, GF_MUL_0D);
    col_out_c[15:8]  = gf_mul(s0, GF_MUL_0D) ^ gf_mul(s1, GF_MUL_09) ^
                       gf_mul(s2, GF_MUL_0E) ^ gf_mul(s3, GF_MUL_0B);
    col_out_c[7:0]   = gf_mul(s0, GF_MUL_0B) ^ gf_mul(s1, GF_MUL_0D) ^
                       gf_mul(s2, GF_MUL_09) ^ gf_mul(s3, GF_MUL_0E);
  end

endmodule

// File: rtl/round_key_reader.sv
// Buffers an expanded AES key and streams round keys forward or reverse over valid/ready.
// Optional ROUND_KEY_EQINV_EN: InvMixColumns on middle decrypt keys (equivalent inverse cipher).
module round_key_reader
  import round_key_reader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load,
  input  logic                          decrypt,
  input  logic [EXPANDED_KEY_WIDTH-1:0] key_reg,
  input  logic                          rk_ready,
  output logic                          rk_valid,
  output logic [KEY_WIDTH-1:0]          rk_data,
  output logic [IDX_W-1:0]              rk_index,
  output logic                          rk_last,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] PENU_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_e                          state_q, state_d;
  logic [EXPANDED_KEY_WIDTH-1:0]   buf_q, buf_d;
  logic                            dec_q, dec_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic                            busy_q, busy_d;
  logic [KEY_WIDTH-1:0]            raw_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      dec_q   <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dec_q   <= dec_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: load only from IDLE; step the index on each accepted key
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dec_d   = dec_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = STREAM;
          buf_d   = key_reg;
          dec_d   = decrypt;
          idx_d   = decrypt ? LAST_IDX : '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (valid_q && rk_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else if (dec_q) begin
            idx_d  = idx_q - IDX_W'(1);
            last_d = (idx_q == IDX_W'(1));
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            last_d = (idx_q == PENU_IDX);
          end
        end
      end
    endcase
  end

  // Select the current round key from the registered buffer
  always_comb begin
    raw_key = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (idx_q == IDX_W'(i)) raw_key = buf_q[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

`ifdef ROUND_KEY_EQINV_EN
  logic [KEY_WIDTH-1:0] imc_key;
  logic                 use_imc;

  for (genvar c = 0; c < int'(COLS); c++) begin : g_imc
    inv_mix_columns_word u_imc (
      .col_in    (raw_key[c*WORD_W +: WORD_W]),
      .col_out_c (imc_key[c*WORD_W +: WORD_W])
    );
  end

  assign use_imc = dec_q && (idx_q != '0) && (idx_q != LAST_IDX);
  assign rk_data = use_imc ? imc_key : raw_key;
`else
  assign rk_data = raw_key;
`endif

  assign rk_valid = valid_q;
  assign rk_index = idx_q;
  assign rk_last  = last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_round_key_reader.sv
// Directed table-driven bench for round_key_reader using the FIPS-197 A.1 key schedule.
module tb_round_key_reader;

  logic          clk;
  logic          reset_n;
  logic          load;
  logic          decrypt;
  logic [1407:0] key_reg;
  logic          rk_ready;
  logic          rk_valid;
  logic [127:0]  rk_data;
  logic [3:0]    rk_index;
  logic          rk_last;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  round_key_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .decrypt  (decrypt),
    .key_reg  (key_reg),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct packed {
    logic       ready;
    logic       ld;
    logic       ev;
    logic [3:0] ei;
    logic       el;
    logic       eb;
  } vec_t;

  vec_t tbl[$];
  logic [1407:0] full_key;
  logic [1407:0] alt_key;

`ifdef ROUND_KEY_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] imc_key(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] s [0:3];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) s[r] = k[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(s[r], 8'h0e) ^ gmul(s[(r+1)%4], 8'h0b) ^
                               gmul(s[(r+2)%4], 8'h0d) ^ gmul(s[(r+3)%4], 8'h09);
    end
    return o;
  endfunction
`endif

  function automatic logic [127:0] exp_data(input bit dec, input int idx);
`ifdef ROUND_KEY_EQINV_EN
    if (dec && idx != 0 && idx != 10) return imc_key(rk[idx]);
`endif
    return rk[idx];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit dec, input logic [1407:0] key);
    chk("pre_load_valid", 128'(rk_valid), 128'(0));
    key_reg = key;
    decrypt = dec;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_idle", 128'(busy), 128'(0));
  endtask

  task automatic build_linear(input bit dec);
    vec_t v;
    tbl.delete();
    for (int k = 0; k <= 10; k++) begin
      v = '{1'b1, 1'b0, 1'b1, (dec ? 4'(10 - k) : 4'(k)), (k == 10), 1'b1};
      tbl.push_back(v);
    end
    v = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl.push_back(v);
  endtask

  // Ready pattern 1,0,0 repeating; the index advances only on ready cycles
  task automatic build_backpressure();
    vec_t v;
    int k = 0;
    int c = 0;
    tbl.delete();
    while (k <= 10) begin
      v = '{(c % 3 == 0), 1'b0, 1'b1, 4'(k), (k == 10), 1'b1};
      tbl.push_back(v);
      if (c % 3 == 0) k++;
      c++;
    end
    v = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl.push_back(v);
  endtask

  task automatic run_table(input bit dec, input string tag);
    vec_t v;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rk_ready = v.ready;
      if (v.ld) begin
        load    = 1'b1;
        decrypt = ~dec;
        key_reg = alt_key;
      end
      chk($sformatf("%s[%0d].valid", tag, i), 128'(rk_valid), 128'(v.ev));
      chk($sformatf("%s[%0d].busy", tag, i), 128'(busy), 128'(v.eb));
      chk($sformatf("%s[%0d].last", tag, i), 128'(rk_last), 128'(v.el));
      if (v.ev) begin
        chk($sformatf("%s[%0d].index", tag, i), 128'(rk_index), 128'(v.ei));
        chk($sformatf("%s[%0d].data", tag, i), rk_data, exp_data(dec, int'(v.ei)));
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i <= 10; i++) full_key[(i+1)*128-1 -: 128] = rk[i];
    alt_key  = ~full_key;
    reset_n  = 1'b0;
    load     = 1'b0;
    decrypt  = 1'b0;
    rk_ready = 1'b0;
    key_reg  = full_key;
    repeat (3) tick();
    chk("rst.valid", 128'(rk_valid), 128'(0));
    chk("rst.last", 128'(rk_last), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.index", 128'(rk_index), 128'(0));
    chk("rst.data", rk_data, 128'(0));
    reset_n = 1'b1;
    tick();

    do_load(1'b0, full_key);
    build_linear(1'b0);
    run_table(1'b0, "fwd");

    wait_idle();
    do_load(1'b1, full_key);
    build_linear(1'b1);
    run_table(1'b1, "rev");

    wait_idle();
    do_load(1'b0, full_key);
    build_backpressure();
    run_table(1'b0, "bp");

    // Reload attempts mid-stream and on the final transfer, key_reg changed after load
    wait_idle();
    do_load(1'b0, full_key);
    key_reg = alt_key;
    build_linear(1'b0);
    tbl[3].ld  = 1'b1;
    tbl[10].ld = 1'b1;
    run_table(1'b0, "ign");

    wait_idle();
    do_load(1'b0, full_key);
    rk_ready = 1'b1;
    repeat (5) tick();
    chk("mid.index5", 128'(rk_index), 128'(5));
    chk("mid.data5", rk_data, rk[5]);
    reset_n = 1'b0;
    #1;
    chk("mid_rst.valid", 128'(rk_valid), 128'(0));
    chk("mid_rst.last", 128'(rk_last), 128'(0));
    chk("mid_rst.busy", 128'(busy), 128'(0));
    chk("mid_rst.index", 128'(rk_index), 128'(0));
    chk("mid_rst.data", rk_data, 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    do_load(1'b0, full_key);
    build_linear(1'b0);
    run_table(1'b0, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
